// File: rtl/nearest_pkg.sv
// Shared types and distance helpers for the nearest-value tracker.
// Build option: define NEAREST_WRAP_DIST_EN to make wrap_dist compute the
// circular distance; otherwise wrap_dist passes the linear distance through.
package nearest_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} nvt_state_t;

  // Helpers work on a fixed 32-bit container; callers zero-extend and truncate.
  localparam int NVT_FN_W = 32;

  function automatic logic [NVT_FN_W-1:0] abs_diff(input logic [NVT_FN_W-1:0] a,
                                                   input logic [NVT_FN_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // ad is |x-r| for a w-bit operand pair; returns the metric actually used.
  function automatic logic [NVT_FN_W-1:0] wrap_dist(input logic [NVT_FN_W-1:0] ad,
                                                    input int unsigned w);
`ifdef NEAREST_WRAP_DIST_EN
    logic [NVT_FN_W:0] span;
    logic [NVT_FN_W:0] comp;
    span = {{NVT_FN_W{1'b0}}, 1'b1} << w;
    comp = span - {1'b0, ad};
    // ad==0 gives comp==2^w, so the plain difference (0) is kept
    return (comp < {1'b0, ad}) ? comp[NVT_FN_W-1:0] : ad;
`else
    int unsigned unused_w;
    unused_w = w;
    return ad;
`endif
  endfunction

endpackage

// File: rtl/dist_unit.sv
// Combinational distance between a candidate and the reference.
// The metric follows NEAREST_WRAP_DIST_EN through nearest_pkg::wrap_dist.
module dist_unit
  import nearest_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] d
);

  // Linear |x-r| first, then optional fold onto the circle.
  assign d = WIDTH'(wrap_dist(abs_diff(NVT_FN_W'(x), NVT_FN_W'(r)), WIDTH));

endmodule

// File: rtl/nearest_value_tracker.sv
// Serial nearest-value search: latch a reference, accept COUNT candidates over
// valid/ready, report the closest one (value, arrival index, distance).
// Build option: NEAREST_WRAP_DIST_EN selects circular distance in dist_unit.
//
// state | meaning
// IDLE  | waiting for start; in_ready low, best_* hold last result
// SCAN  | accepting candidates; in_ready high
// DONE  | one-cycle result pulse, then back to IDLE
module nearest_value_tracker
  import nearest_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int COUNT = 4,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ref_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] best_val,
  output logic [IDX_W-1:0] best_idx,
  output logic [WIDTH-1:0] best_dist
);

  nvt_state_t       state;
  logic [IDX_W-1:0] count;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cand_dist;
  logic             accept;
  logic             last;
  logic             better;

  dist_unit #(.WIDTH(WIDTH)) u_dist (
    .x (in_data),
    .r (ref_q),
    .d (cand_dist)
  );

  // in_ready is registered and high exactly in SCAN, so it doubles as the state qualifier
  assign accept = in_valid & in_ready;
  assign last   = (count == IDX_W'(COUNT - 1));
  // strict less-than keeps the earlier candidate on ties
  assign better = (count == '0) || (cand_dist < best_dist);

  // Sequencer, candidate counter and best-so-far registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_val  <= '0;
      best_idx  <= '0;
      best_dist <= '0;
      count     <= '0;
      ref_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ref_q    <= ref_in;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (accept) begin
            if (better) begin
              best_val  <= in_data;
              best_idx  <= count;
              best_dist <= cand_dist;
            end
            if (last) begin
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
